// File: rtl/ov7670_cap_pkg.sv
// ov7670_cap_pkg: shared FSM state encoding, RGB565 pixel layout and 12-bit saturating counter helper
package ov7670_cap_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT_VS, S_ACTIVE} cap_state_e;
  localparam int CNT_W = 12;
  localparam int R_W = 5;
  localparam int G_W = 6;
  localparam int B_W = 5;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } rgb565_t;
  function automatic cnt_t sat_inc(cnt_t v);
    return (&v) ? v : v + cnt_t'(1);
  endfunction
endpackage

// File: rtl/ov7670_capture_writer_if.sv
// ov7670_capture_writer_if: frame-buffer write port (w_addr, d_in_a, w_en_a); master drives, slave is the buffer
interface ov7670_capture_writer_if #(parameter int ADDR_W = 16);
  logic [ADDR_W-1:0] w_addr;
  logic [15:0]       d_in_a;
  logic              w_en_a;
  modport master (output w_addr, d_in_a, w_en_a);
  modport slave  (input  w_addr, d_in_a, w_en_a);
endinterface

// File: rtl/ov7670_capture_writer_cap_byte_pack.sv
// cap_byte_pack: pairs camera bytes into 16-bit pixels
//   clk, rst_n     write clock, async active-low reset
//   en_i           byte valid (capturing and HREF high); low forces phase back to the high byte
//   d_i            camera byte
//   pix_valid_o    high while the second byte of a pixel is on d_i
//   pix_o          {latched high byte, d_i}
module cap_byte_pack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic [7:0]  d_i,
  output logic        pix_valid_o,
  output logic [15:0] pix_o
);
  logic       phase_q;
  logic [7:0] hi_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      phase_q <= 1'b0;
      hi_q    <= '0;
    end else begin
      phase_q <= en_i & ~phase_q;
      if (en_i & ~phase_q) hi_q <= d_i;
    end
  assign pix_valid_o = en_i & phase_q;
  assign pix_o       = {hi_q, d_i};
endmodule

// File: rtl/ov7670_capture_writer.sv
// ov7670_capture_writer: samples OV7670 VSYNC/HREF/D, packs RGB565, crops a window and writes the frame buffer
//   w_clk, rst_n   write clock, async active-low reset
//   cap_en         capture continuously while high; dropping it lets the current frame finish
//   cam_vsync/href/d  camera inputs, synchronous to w_clk
//   buf_if         buffer write port (master)
//   frame_done     one-cycle pulse at the end of each captured frame
//   busy           high while waiting for or capturing a frame
//   CAP_DECIM_EN   define for 2x decimation (even raw columns of even raw lines, window on raw>>1)
module ov7670_capture_writer
  import ov7670_cap_pkg::*;
#(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int X_OFF  = 0,
  parameter int Y_OFF  = 0,
  parameter int ADDR_W = 16
) (
  input  logic                     w_clk,
  input  logic                     rst_n,
  input  logic                     cap_en,
  input  logic                     cam_vsync,
  input  logic                     cam_href,
  input  logic [7:0]               cam_d,
  ov7670_capture_writer_if.master  buf_if,
  output logic                     frame_done,
  output logic                     busy
);
  localparam logic [ADDR_W:0] NPIX = (ADDR_W+1)'(IMG_W * IMG_H);
  cap_state_e        state_q, state_d;
  logic              vs_q, hr_q, vs_rise, vs_fall, hr_fall, active, start, done;
  logic              pix_v, keep, accept, we_q, fd_q;
  logic [15:0]       pix;
  cnt_t              cx_q, cy_q;
  int                ex, ey;
  logic [ADDR_W:0]   wp_q;
  logic [ADDR_W-1:0] addr_q;
  rgb565_t           data_q;
  assign vs_rise = cam_vsync & ~vs_q;
  assign vs_fall = ~cam_vsync & vs_q;
  assign hr_fall = ~cam_href & hr_q;
  assign active  = state_q == S_ACTIVE;
  cap_byte_pack u_pack (
    .clk        (w_clk),
    .rst_n      (rst_n),
    .en_i       (active & cam_href),
    .d_i        (cam_d),
    .pix_valid_o(pix_v),
    .pix_o      (pix)
  );
`ifdef CAP_DECIM_EN
  assign keep = ~cx_q[0] & ~cy_q[0];
  assign ex   = int'(cx_q[CNT_W-1:1]);
  assign ey   = int'(cy_q[CNT_W-1:1]);
`else
  assign keep = 1'b1;
  assign ex   = int'(cx_q);
  assign ey   = int'(cy_q);
`endif
  // once the pointer reaches IMG_W*IMG_H the rest of the frame is dropped, never wrapped
  assign accept = pix_v & keep & (ex >= X_OFF) & (ex < X_OFF + IMG_W)
                & (ey >= Y_OFF) & (ey < Y_OFF + IMG_H) & (wp_q < NPIX);
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    state_d = cap_en ? S_WAIT_VS : S_IDLE;
      S_WAIT_VS: state_d = !cap_en ? S_IDLE : vs_fall ? S_ACTIVE : S_WAIT_VS;
      S_ACTIVE:  state_d = !vs_rise ? S_ACTIVE : cap_en ? S_WAIT_VS : S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    start = (state_q == S_WAIT_VS) && (state_d == S_ACTIVE);
    done  = active && vs_rise;
  end
  always_ff @(posedge w_clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      vs_q    <= 1'b0;
      hr_q    <= 1'b0;
      fd_q    <= 1'b0;
      we_q    <= 1'b0;
      cx_q    <= '0;
      cy_q    <= '0;
      wp_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      vs_q    <= cam_vsync;
      hr_q    <= cam_href;
      fd_q    <= done;
      we_q    <= accept;
      if (start) begin
        cx_q   <= '0;
        cy_q   <= '0;
        wp_q   <= '0;
        addr_q <= '0;
      end else begin
        if (active && hr_fall) begin
          cx_q <= '0;
          cy_q <= sat_inc(cy_q);
        end else if (pix_v) cx_q <= sat_inc(cx_q);
        if (accept) begin
          addr_q <= wp_q[ADDR_W-1:0];
          data_q <= pix;
          wp_q   <= wp_q + (ADDR_W+1)'(1);
        end
      end
    end
  assign buf_if.w_addr = addr_q;
  assign buf_if.d_in_a = data_q;
  assign buf_if.w_en_a = we_q;
  assign frame_done    = fd_q;
  assign busy          = state_q != S_IDLE;
endmodule

// File: tb/tb_ov7670_capture_writer.sv
// tb_ov7670_capture_writer: scoreboard bench driving three differently cropped writers from one camera stream
module tb_ov7670_capture_writer;
  logic       w_clk = 1'b0, rst_n = 1'b0, cap_en = 1'b0, cam_vsync = 1'b0, cam_href = 1'b0;
  logic [7:0] cam_d = '0;
  logic [2:0] fd, bz, we;
  logic [15:0] ad [3];
  logic [15:0] dt [3];
  localparam int PW [3] = '{4, 4, 8};
  localparam int PH [3] = '{2, 2, 4};
  localparam int PX [3] = '{0, 2, 0};
  localparam int PY [3] = '{0, 1, 0};
  logic [31:0] exp_q [3][$];
  int cnt [3];
  int fd_cnt [3];
  int coinc = 0, n_chk = 0, n_err = 0;
  always #20 w_clk = ~w_clk;
  ov7670_capture_writer_if bus_a (), bus_b (), bus_c ();
  ov7670_capture_writer #(.IMG_W(4), .IMG_H(2)) dut_a (.w_clk(w_clk), .rst_n(rst_n), .cap_en(cap_en),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_d(cam_d), .buf_if(bus_a), .frame_done(fd[0]), .busy(bz[0]));
  ov7670_capture_writer #(.IMG_W(4), .IMG_H(2), .X_OFF(2), .Y_OFF(1)) dut_b (.w_clk(w_clk), .rst_n(rst_n),
    .cap_en(cap_en), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_d(cam_d), .buf_if(bus_b),
    .frame_done(fd[1]), .busy(bz[1]));
  ov7670_capture_writer #(.IMG_W(8), .IMG_H(4)) dut_c (.w_clk(w_clk), .rst_n(rst_n), .cap_en(cap_en),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_d(cam_d), .buf_if(bus_c), .frame_done(fd[2]), .busy(bz[2]));
  assign we = {bus_c.w_en_a, bus_b.w_en_a, bus_a.w_en_a};
  assign ad[0] = bus_a.w_addr;
  assign ad[1] = bus_b.w_addr;
  assign ad[2] = bus_c.w_addr;
  assign dt[0] = bus_a.d_in_a;
  assign dt[1] = bus_b.d_in_a;
  assign dt[2] = bus_c.d_in_a;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic mon();
    logic [31:0] e;
    for (int i = 0; i < 3; i++) begin
      if (fd[i]) fd_cnt[i]++;
      if (i == 2 && we[i] && fd[i]) coinc++;
      if (we[i]) begin
        e = 32'hFFFF_FFFF;
        if (exp_q[i].size() > 0) e = exp_q[i].pop_front();
        chk($sformatf("wr%0d", i), {ad[i], dt[i]}, e);
      end
    end
  endtask
  task automatic tick();
    @(negedge w_clk);
    mon();
    @(posedge w_clk);
    #1;
  endtask
  task automatic model(input int x, input int y, input logic [15:0] p);
    int ex, ey;
    bit keep;
`ifdef CAP_DECIM_EN
    keep = (x % 2 == 0) && (y % 2 == 0);
    ex = x / 2;
    ey = y / 2;
`else
    keep = 1'b1;
    ex = x;
    ey = y;
`endif
    for (int i = 0; i < 3; i++)
      if (keep && ex >= PX[i] && ex < PX[i] + PW[i] && ey >= PY[i] && ey < PY[i] + PH[i]
          && cnt[i] < PW[i] * PH[i]) begin
        exp_q[i].push_back({16'(cnt[i]), p});
        cnt[i]++;
      end
  endtask
  task automatic chk_reset(input string tag);
    for (int i = 0; i < 3; i++)
      chk($sformatf("%s%0d", tag, i), {bz[i], fd[i], we[i], ad[i], dt[i]}, 64'd0);
  endtask
  task automatic frame(input int nl, input int nb, input bit cap, input int drop_at, input int abort_at,
                       input bit tight);
    int fd0 [3];
    logic [7:0] b, hi;
    int k;
    fd0 = fd_cnt;
    cnt = '{0, 0, 0};
    k = 0;
    hi = '0;
    cam_vsync = 1'b1;
    repeat (4) tick();
    cam_vsync = 1'b0;
    repeat (3) tick();
    for (int y = 0; y < nl; y++) begin
      if (y == abort_at) begin
        repeat (3) tick();
        for (int i = 0; i < 3; i++) chk($sformatf("drain%0d", i), 64'(exp_q[i].size()), 64'd0);
        rst_n = 1'b0;
        tick();
        chk_reset("midrst");
        for (int i = 0; i < 3; i++) chk($sformatf("rst_fd%0d", i), 64'(fd_cnt[i] - fd0[i]), 64'd0);
        rst_n = 1'b1;
        tick();
        return;
      end
      if (y == drop_at) cap_en = 1'b0;
      cam_href = 1'b1;
      for (int x = 0; x < nb; x++) begin
        b = 8'(8'hAB + 8'h22 * k);
        k++;
        cam_d = b;
        if (x % 2 == 0) hi = b;
        else if (cap) model(x / 2, y, {hi, b});
        if (tight && y == nl - 1 && x == nb - 1) cam_vsync = 1'b1;
        tick();
      end
      cam_href = 1'b0;
      cam_d = '0;
      repeat (3) tick();
    end
    cam_vsync = 1'b1;
    repeat (5) tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("fd%0d", i), 64'(fd_cnt[i] - fd0[i]), 64'(cap));
      chk($sformatf("left%0d", i), 64'(exp_q[i].size()), 64'd0);
    end
  endtask
  initial begin
    fd_cnt = '{0, 0, 0};
    repeat (3) tick();
    chk_reset("rst");
    rst_n = 1'b1;
    tick();
    cap_en = 1'b1;
    tick();
    frame(4, 12, 1'b1, -1, -1, 1'b0);
    frame(3, 7, 1'b1, -1, -1, 1'b0);
    frame(4, 16, 1'b1, -1, 2, 1'b0);
    frame(4, 16, 1'b1, -1, -1, 1'b0);
    frame(1, 10, 1'b1, -1, -1, 1'b1);
    chk("coinc", 64'(coinc), 64'd1);
    frame(3, 12, 1'b1, 1, -1, 1'b0);
    for (int i = 0; i < 3; i++) chk($sformatf("idle%0d", i), 64'(bz[i]), 64'd0);
    frame(2, 12, 1'b0, -1, -1, 1'b0);
    for (int i = 0; i < 3; i++) chk($sformatf("idle2_%0d", i), 64'(bz[i]), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
